// File: rtl/dcache_refill.sv
// Dcache miss-side writer: fetches one line from memory into the data RAM, then installs
// {valid, tag} in the tag RAM. Also performs single-cycle line invalidates.
module dcache_refill #(
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 20,
  parameter int IDX_W      = 7,
  localparam int CNT_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tag_work,
  input  logic             miss_valid,
  input  logic [31:0]      miss_addr,
  output logic             miss_ready,
  input  logic             inv_valid,
  input  logic [31:0]      inv_addr,
  output logic             inv_ready,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic             rd_rdy,
  input  logic             ret_valid,
  input  logic             ret_last,
  input  logic [31:0]      ret_data,
  output logic             data_wen,
  output logic [IDX_W-1:0] data_index,
  output logic [CNT_W-1:0] data_word,
  output logic [31:0]      data_wdata,
  output logic             tag_wen,
  output logic [31:0]      tag_addr,
  output logic [TAG_W:0]   tag_wdata,
  output logic             refill_done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RECV = 3'd2,
    S_TAG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_err;

  logic w_idle_ok;
  logic w_inv_acc;
  logic w_miss_acc;
  logic w_recv_wr;
  logic w_last_word;

  // resetn gates the handshakes so nothing is accepted while reset is asserted
  assign w_idle_ok   = resetn && (r_state == S_IDLE) && tag_work;
  assign w_inv_acc   = w_idle_ok && inv_valid;
  assign w_miss_acc  = w_idle_ok && !inv_valid && miss_valid;
  assign w_recv_wr   = resetn && (r_state == S_RECV) && ret_valid;
  assign w_last_word = (r_cnt == CNT_W'(LINE_WORDS - 1));

  // Refill sequencer, word counter, latched miss address and sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss_acc) begin
            r_addr  <= miss_addr;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_rdy) begin
            r_cnt   <= '0;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (ret_valid) begin
            r_cnt <= r_cnt + 1'b1;
            // ret_last must coincide exactly with the final counted word
            if (ret_last != w_last_word) begin
              r_err <= 1'b1;
            end
            if (w_last_word) begin
              r_state <= S_TAG;
            end
          end
        end
        S_TAG:   r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode; tag and data strobes come from disjoint states
  always_comb begin
    miss_ready  = w_miss_acc;
    inv_ready   = w_inv_acc;
    rd_req      = (r_state == S_REQ);
    rd_addr     = 32'h0;
    data_wen    = w_recv_wr;
    data_index  = r_addr[5 +: IDX_W];
    data_word   = r_cnt;
    data_wdata  = 32'h0;
    tag_wen     = 1'b0;
    tag_addr    = 32'h0;
    tag_wdata   = '0;
    refill_done = (r_state == S_DONE);
    err         = r_err;
    if (r_state == S_REQ) begin
      rd_addr = {r_addr[31:5], 5'b0};
    end else begin
      rd_addr = 32'h0;
    end
    if (w_recv_wr) begin
      data_wdata = ret_data;
    end else begin
      data_wdata = 32'h0;
    end
    if (w_inv_acc) begin
      tag_wen  = 1'b1;
      tag_addr = inv_addr;
    end else if (r_state == S_TAG) begin
      tag_wen   = 1'b1;
      tag_addr  = r_addr;
      tag_wdata = {1'b1, r_addr[31 -: TAG_W]};
    end else begin
      tag_wen = 1'b0;
    end
  end

endmodule
